// File: rtl/asteroids_pkg.sv
// Shared definitions for the asteroids entity pipeline.
// Contents:
//   ENTITY_SIZE          width of one packed entity word
//   *_BIT / *_HI / *_LO  field positions inside an entity word
//   SHOT_TYPE            type code carried by shot entities
//   SCREEN_W / SCREEN_H  playfield size in pixels
//   pack_shot()          builds an active shot word from its fields
package asteroids_pkg;

    localparam int ENTITY_SIZE = 34;

    localparam int ACTIVE_BIT = 33;
    localparam int TYPE_HI    = 32;
    localparam int TYPE_LO    = 30;
    localparam int Y_HI       = 25;
    localparam int Y_LO       = 16;
    localparam int X_HI       = 15;
    localparam int X_LO       = 6;
    localparam int DIR_HI     = 5;
    localparam int DIR_LO     = 0;

    localparam logic [2:0] SHOT_TYPE = 3'b010;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    function automatic logic [ENTITY_SIZE-1:0] pack_shot(
        input logic [9:0] y,
        input logic [9:0] x,
        input logic [5:0] dir
    );
        logic [ENTITY_SIZE-1:0] w;
        w                  = '0;
        w[ACTIVE_BIT]      = 1'b1;
        w[TYPE_HI:TYPE_LO] = SHOT_TYPE;
        w[Y_HI:Y_LO]       = y;
        w[X_HI:X_LO]       = x;
        w[DIR_HI:DIR_LO]   = dir;
        return w;
    endfunction

endpackage

// File: rtl/shot_velocity_lut.sv
// Per-heading shot velocity lookup (combinational).
// Ports:
//   sector  in   heading sector, dir[5:3]
//   dx, dy  out  signed per-tick displacement in pixels
module shot_velocity_lut (
    input  logic              [2:0] sector,
    output logic signed       [2:0] dx,
    output logic signed       [2:0] dy
);

    // Sector 0 points up the screen (negative y), rotating clockwise.
    always_comb begin
        dx = 3'sd0;
        dy = 3'sd0;
        case (sector)
            3'd0: begin dx =  3'sd0; dy = -3'sd2; end
            3'd1: begin dx =  3'sd2; dy = -3'sd2; end
            3'd2: begin dx =  3'sd2; dy =  3'sd0; end
            3'd3: begin dx =  3'sd2; dy =  3'sd2; end
            3'd4: begin dx =  3'sd0; dy =  3'sd2; end
            3'd5: begin dx = -3'sd2; dy =  3'sd2; end
            3'd6: begin dx = -3'sd2; dy =  3'sd0; end
            default: begin dx = -3'sd2; dy = -3'sd2; end
        endcase
    end

endmodule

// File: rtl/shot_controller.sv
// Shot spawner and mover: owns MAX_SHOTS shot slots, spawns one shot per
// fire press into the lowest free slot, moves live shots each tick with
// screen wrap, and retires them on kill or lifetime expiry.
// Ports:
//   move_clk      in   movement tick clock
//   reset_n       in   asynchronous reset, active-high
//   fire          in   fire key level (high = pressed)
//   ship_x/ship_y in   ship position, spawn origin
//   ship_dir      in   ship heading, copied into the shot
//   kill          in   per-slot destroy request from collision
//   shots         out  packed shot words, all-zero when the slot is idle
//   fire_ack      out  one-tick pulse after a successful spawn
//   active_count  out  number of live slots
module shot_controller
    import asteroids_pkg::*;
#(
    parameter int ENTITY_SIZE = asteroids_pkg::ENTITY_SIZE,
    parameter int MAX_SHOTS   = 3,
    parameter int LIFETIME    = 60,
    parameter int COOLDOWN    = 8,
    parameter int SCREEN_W    = asteroids_pkg::SCREEN_W,
    parameter int SCREEN_H    = asteroids_pkg::SCREEN_H
) (
    input  logic                                   move_clk,
    input  logic                                   reset_n,
    input  logic                                   fire,
    input  logic [9:0]                             ship_x,
    input  logic [9:0]                             ship_y,
    input  logic [5:0]                             ship_dir,
    input  logic [MAX_SHOTS-1:0]                   kill,
    output logic [MAX_SHOTS-1:0][ENTITY_SIZE-1:0]  shots,
    output logic                                   fire_ack,
    output logic [$clog2(MAX_SHOTS+1)-1:0]         active_count
);

    localparam int CD_W   = $clog2(COOLDOWN + 1);
    localparam int LIFE_W = $clog2(LIFETIME + 1);
    localparam int CNT_W  = $clog2(MAX_SHOTS + 1);

    // One coordinate step with toroidal wrap; the step is at most 2 pixels,
    // so a single add or subtract of the screen size always lands in range.
    function automatic logic [9:0] wrap_coord(
        input logic        [9:0] pos,
        input logic signed [2:0] d,
        input int                limit
    );
        logic signed [10:0] sum;
        sum = $signed({1'b0, pos}) + 11'(d);
        if (sum < 0)
            sum = sum + 11'(limit);
        else if (sum >= 11'(limit))
            sum = sum - 11'(limit);
        return sum[9:0];
    endfunction

    logic                  fire_q;
    logic [CD_W-1:0]       cooldown;
    logic [LIFE_W-1:0]     life [MAX_SHOTS];

    logic [MAX_SHOTS-1:0]  active;
    logic [MAX_SHOTS-1:0]  free;
    logic [MAX_SHOTS-1:0]  spawn_slot;
    logic                  spawn_req;
    logic                  spawn_ok;
    logic [9:0]            move_x [MAX_SHOTS];
    logic [9:0]            move_y [MAX_SHOTS];

    for (genvar g = 0; g < MAX_SHOTS; g++) begin : g_slot
        logic signed [2:0] dx;
        logic signed [2:0] dy;

        shot_velocity_lut u_lut (
            .sector (shots[g][DIR_HI:DIR_HI-2]),
            .dx     (dx),
            .dy     (dy)
        );

        assign active[g] = shots[g][ACTIVE_BIT];
        // A slot being killed this tick is not free even if already idle.
        assign free[g]   = ~active[g] & ~kill[g];
        assign move_x[g] = wrap_coord(shots[g][X_HI:X_LO], dx, SCREEN_W);
        assign move_y[g] = wrap_coord(shots[g][Y_HI:Y_LO], dy, SCREEN_H);
    end

    // Lowest-index free slot as a one-hot vector.
    always_comb begin
        logic taken;
        taken      = 1'b0;
        spawn_slot = '0;
        for (int i = 0; i < MAX_SHOTS; i++) begin
            if (free[i] && !taken) begin
                spawn_slot[i] = 1'b1;
                taken         = 1'b1;
            end
        end
    end

    assign spawn_req = fire & ~fire_q;
    assign spawn_ok  = spawn_req && (cooldown == '0) && (spawn_slot != '0);

    always_comb begin
        active_count = '0;
        for (int i = 0; i < MAX_SHOTS; i++)
            active_count = active_count + CNT_W'(active[i]);
    end

    always_ff @(posedge move_clk or posedge reset_n) begin
        if (reset_n) begin
            fire_q   <= 1'b0;
            fire_ack <= 1'b0;
            cooldown <= '0;
            shots    <= '0;
            for (int i = 0; i < MAX_SHOTS; i++)
                life[i] <= '0;
        end else begin
            fire_q   <= fire;
            fire_ack <= spawn_ok;

            if (spawn_ok)
                cooldown <= CD_W'(COOLDOWN);
            else if (cooldown != '0)
                cooldown <= cooldown - CD_W'(1);

            for (int i = 0; i < MAX_SHOTS; i++) begin
                if (spawn_ok && spawn_slot[i]) begin
                    // Freshly spawned shots sit at the ship for one tick.
                    shots[i] <= ENTITY_SIZE'(pack_shot(ship_y, ship_x, ship_dir));
                    life[i]  <= LIFE_W'(LIFETIME);
                end else if (active[i]) begin
                    if (kill[i] || life[i] == LIFE_W'(1)) begin
                        shots[i] <= '0;
                        life[i]  <= '0;
                    end else begin
                        shots[i] <= ENTITY_SIZE'(pack_shot(move_y[i], move_x[i],
                                                           shots[i][DIR_HI:DIR_LO]));
                        life[i]  <= life[i] - LIFE_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_shot_controller.sv
// Self-checking bench for shot_controller: a behavioural model predicts each
// tick's outputs into a scoreboard queue; each scenario task pops and checks.
module tb_shot_controller;

    localparam int N = 3;

    logic              move_clk = 1'b0;
    logic              reset_n  = 1'b1;
    logic              fire     = 1'b0;
    logic [9:0]        ship_x   = '0;
    logic [9:0]        ship_y   = '0;
    logic [5:0]        ship_dir = '0;
    logic [N-1:0]      kill     = '0;
    logic [N-1:0][33:0] shots;
    logic              fire_ack;
    logic [1:0]        active_count;

    shot_controller dut (
        .move_clk     (move_clk),
        .reset_n      (reset_n),
        .fire         (fire),
        .ship_x       (ship_x),
        .ship_y       (ship_y),
        .ship_dir     (ship_dir),
        .kill         (kill),
        .shots        (shots),
        .fire_ack     (fire_ack),
        .active_count (active_count)
    );

    always #5 move_clk = ~move_clk;

    typedef struct {
        logic [N-1:0][33:0] shots;
        logic               ack;
        logic [1:0]         cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bit m_act [N];
    int m_x [N], m_y [N], m_dir [N], m_life [N];
    int m_cd;
    bit m_fq;
    int DXT [8] = '{0, 2, 2, 2, 0, -2, -2, -2};
    int DYT [8] = '{-2, -2, 0, 2, 2, 2, 0, -2};

    function automatic logic [33:0] word_of(int i);
        if (!m_act[i]) return 34'd0;
        return {1'b1, 3'b010, 4'b0000, 10'(m_y[i]), 10'(m_x[i]), 6'(m_dir[i])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_life[i] = 0;
        end
        m_cd = 0;
        m_fq = 0;
        sb.delete();
    endtask

    // Predict the next tick from current inputs, queue it, then clock.
    task automatic step();
        exp_t e;
        bit   ok;
        int   slot;
        slot = -1;
        for (int i = 0; i < N; i++)
            if (slot < 0 && !m_act[i] && !kill[i]) slot = i;
        ok = fire && !m_fq && m_cd == 0 && slot >= 0;
        for (int i = 0; i < N; i++) begin
            if (ok && i == slot) begin
                m_act[i] = 1; m_x[i] = ship_x; m_y[i] = ship_y;
                m_dir[i] = ship_dir; m_life[i] = 60;
            end else if (m_act[i]) begin
                if (kill[i] || m_life[i] == 1) m_act[i] = 0;
                else begin
                    m_x[i] = (m_x[i] + DXT[m_dir[i] / 8] + 320) % 320;
                    m_y[i] = (m_y[i] + DYT[m_dir[i] / 8] + 240) % 240;
                    m_life[i]--;
                end
            end
        end
        m_cd = ok ? 8 : (m_cd > 0 ? m_cd - 1 : 0);
        m_fq = fire;
        e.ack = ok;
        e.cnt = 2'd0;
        for (int i = 0; i < N; i++) begin
            e.shots[i] = word_of(i);
            e.cnt      = e.cnt + 2'(m_act[i]);
        end
        sb.push_back(e);
        @(posedge move_clk);
        #1;
    endtask

    task automatic apply_reset();
        fire    = 1'b0;
        kill    = '0;
        reset_n = 1'b1;
        @(posedge move_clk);
        #1;
        reset_n = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(posedge move_clk);
        #1;
        n_checks++; if (shots !== '0) begin n_fail++; $display("FAIL reset_shots got %h want 0", shots); end
        n_checks++; if (fire_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", fire_ack); end
        n_checks++; if (active_count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", active_count); end
        reset_n = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        exp_t e;
        ship_x = 10'd100; ship_y = 10'd50; ship_dir = 6'd0;
        fire = 1'b1; step(); fire = 1'b0;
        e = sb.pop_front();
        n_checks++; if (shots !== e.shots) begin n_fail++; $display("FAIL basic_sb_shots got %h want %h", shots, e.shots); end
        n_checks++; if (shots[0] !== {1'b1, 3'b010, 4'b0, 10'd50, 10'd100, 6'd0}) begin n_fail++; $display("FAIL basic_spawn_word got %h", shots[0]); end
        n_checks++; if (fire_ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack got %b want 1", fire_ack); end
        for (int k = 0; k < 59; k++) begin
            step();
            e = sb.pop_front();
            n_checks++; if (shots !== e.shots) begin n_fail++; $display("FAIL basic_sb_shots t%0d got %h want %h", k, shots, e.shots); end
            n_checks++; if (fire_ack !== e.ack) begin n_fail++; $display("FAIL basic_sb_ack t%0d got %b want %b", k, fire_ack, e.ack); end
            n_checks++; if (active_count !== e.cnt) begin n_fail++; $display("FAIL basic_sb_cnt t%0d got %0d want %0d", k, active_count, e.cnt); end
            if (k == 0) begin
                n_checks++; if (shots[0][25:16] !== 10'd48) begin n_fail++; $display("FAIL basic_move_y got %0d want 48", shots[0][25:16]); end
            end
        end
        n_checks++; if (active_count !== 2'd1) begin n_fail++; $display("FAIL basic_last_tick_count got %0d want 1", active_count); end
        step();
        e = sb.pop_front();
        n_checks++; if (shots !== e.shots) begin n_fail++; $display("FAIL basic_expire_sb got %h want %h", shots, e.shots); end
        n_checks++; if (shots[0] !== 34'd0) begin n_fail++; $display("FAIL basic_expire_word got %h want 0", shots[0]); end
        n_checks++; if (active_count !== 2'd0) begin n_fail++; $display("FAIL basic_expire_count got %0d want 0", active_count); end
    endtask

    task automatic test_wrap();
        exp_t e;
        int   xs [2] = '{319, 5};
        int   ys [2] = '{10, 1};
        int   ds [2] = '{16, 56};
        int   wx [2] = '{1, 3};
        int   wy [2] = '{10, 239};
        for (int c = 0; c < 2; c++) begin
            apply_reset();
            ship_x = 10'(xs[c]); ship_y = 10'(ys[c]); ship_dir = 6'(ds[c]);
            fire = 1'b1; step(); fire = 1'b0;
            e = sb.pop_front();
            n_checks++; if (shots !== e.shots) begin n_fail++; $display("FAIL wrap%0d_spawn got %h want %h", c, shots, e.shots); end
            step();
            e = sb.pop_front();
            n_checks++; if (shots !== e.shots) begin n_fail++; $display("FAIL wrap%0d_sb got %h want %h", c, shots, e.shots); end
            n_checks++; if (shots[0][15:6] !== 10'(wx[c])) begin n_fail++; $display("FAIL wrap%0d_x got %0d want %0d", c, shots[0][15:6], wx[c]); end
            n_checks++; if (shots[0][25:16] !== 10'(wy[c])) begin n_fail++; $display("FAIL wrap%0d_y got %0d want %0d", c, shots[0][25:16], wy[c]); end
        end
    endtask

    task automatic test_cooldown_full();
        exp_t e;
        apply_reset();
        ship_x = 10'd200; ship_y = 10'd100; ship_dir = 6'd8;
        for (int p = 0; p < 4; p++) begin
            fire = 1'b1; step(); fire = 1'b0;
            e = sb.pop_front();
            n_checks++; if (shots !== e.shots) begin n_fail++; $display("FAIL full_p%0d_sb got %h want %h", p, shots, e.shots); end
            n_checks++; if (fire_ack !== (p < 3)) begin n_fail++; $display("FAIL full_p%0d_ack got %b want %b", p, fire_ack, p < 3); end
            n_checks++; if (active_count !== 2'(p < 3 ? p + 1 : 3)) begin n_fail++; $display("FAIL full_p%0d_cnt got %0d", p, active_count); end
            for (int k = 0; k < 9; k++) begin
                step();
                e = sb.pop_front();
                n_checks++; if (shots !== e.shots || fire_ack !== e.ack) begin n_fail++; $display("FAIL full_gap_sb got %h/%b want %h/%b", shots, fire_ack, e.shots, e.ack); end
            end
        end
        apply_reset();
        fire = 1'b1; step(); fire = 1'b0;
        e = sb.pop_front();
        n_checks++; if (fire_ack !== e.ack) begin n_fail++; $display("FAIL cd_first_ack got %b want %b", fire_ack, e.ack); end
        repeat (4) begin
            step();
            e = sb.pop_front();
            n_checks++; if (shots !== e.shots) begin n_fail++; $display("FAIL cd_gap_sb got %h want %h", shots, e.shots); end
        end
        fire = 1'b1; step(); fire = 1'b0;
        e = sb.pop_front();
        n_checks++; if (fire_ack !== 1'b0) begin n_fail++; $display("FAIL cd_drop_ack got %b want 0", fire_ack); end
        n_checks++; if (active_count !== 2'd1) begin n_fail++; $display("FAIL cd_drop_cnt got %0d want 1", active_count); end
        n_checks++; if (shots !== e.shots) begin n_fail++; $display("FAIL cd_drop_sb got %h want %h", shots, e.shots); end
    endtask

    task automatic test_kill_spawn();
        exp_t e;
        apply_reset();
        ship_x = 10'd60; ship_y = 10'd70; ship_dir = 6'd24;
        repeat (3) begin
            fire = 1'b1; step(); fire = 1'b0;
            repeat (9) step();
        end
        sb.delete();
        kill = 3'b010; fire = 1'b1; step();
        e = sb.pop_front();
        n_checks++; if (shots !== e.shots) begin n_fail++; $display("FAIL kill_sb got %h want %h", shots, e.shots); end
        n_checks++; if (shots[1] !== 34'd0) begin n_fail++; $display("FAIL kill_slot1 got %h want 0", shots[1]); end
        n_checks++; if (fire_ack !== 1'b0) begin n_fail++; $display("FAIL kill_ack got %b want 0", fire_ack); end
        n_checks++; if (active_count !== 2'd2) begin n_fail++; $display("FAIL kill_cnt got %0d want 2", active_count); end
        kill = '0; fire = 1'b0; step();
        e = sb.pop_front();
        ship_x = 10'd77; fire = 1'b1; step(); fire = 1'b0;
        e = sb.pop_front();
        n_checks++; if (shots !== e.shots) begin n_fail++; $display("FAIL respawn_sb got %h want %h", shots, e.shots); end
        n_checks++; if (fire_ack !== 1'b1) begin n_fail++; $display("FAIL respawn_ack got %b want 1", fire_ack); end
        n_checks++; if (shots[1][15:6] !== 10'd77 || shots[1][33] !== 1'b1) begin n_fail++; $display("FAIL respawn_slot1 got %h want x=77 active", shots[1]); end
        n_checks++; if (active_count !== 2'd3) begin n_fail++; $display("FAIL respawn_cnt got %0d want 3", active_count); end
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        apply_reset();
        ship_x = 10'd150; ship_y = 10'd120; ship_dir = 6'd40;
        fire = 1'b1; step(); fire = 1'b0;
        repeat (9) step();
        fire = 1'b1; step(); fire = 1'b0;
        repeat (2) step();
        sb.delete();
        fire = 1'b1;
        #3;
        reset_n = 1'b1;
        #1;
        n_checks++; if (shots !== '0) begin n_fail++; $display("FAIL midreset_shots got %h want 0", shots); end
        n_checks++; if (fire_ack !== 1'b0) begin n_fail++; $display("FAIL midreset_ack got %b want 0", fire_ack); end
        n_checks++; if (active_count !== 2'd0) begin n_fail++; $display("FAIL midreset_cnt got %0d want 0", active_count); end
        @(posedge move_clk);
        #1;
        reset_n = 1'b0;
        model_reset();
        step();
        fire = 1'b0;
        e = sb.pop_front();
        n_checks++; if (shots !== e.shots) begin n_fail++; $display("FAIL held_fire_sb got %h want %h", shots, e.shots); end
        n_checks++; if (fire_ack !== 1'b1) begin n_fail++; $display("FAIL held_fire_ack got %b want 1", fire_ack); end
        n_checks++; if (active_count !== 2'd1) begin n_fail++; $display("FAIL held_fire_cnt got %0d want 1", active_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_cooldown_full();
        test_kill_spawn();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/shot_controller.md
SHOT_CONTROLLER -- requirements
Module: shot_controller

Interface
REQ-001 Parameter ENTITY_SIZE, 34, width of one packed entity word.
REQ-002 Parameter MAX_SHOTS, 3, number of shot slots.
REQ-003 Parameter LIFETIME, 60, number of move_clk ticks a shot stays active.
REQ-004 Parameter COOLDOWN, 8, minimum number of ticks between spawns.
REQ-005 Parameters SCREEN_W, 320, and SCREEN_H, 240, give the playfield size in pixels.
REQ-006 Clock move_clk, input, 1 bit, the game movement tick; every register in the block updates on its rising edge.
REQ-007 Reset reset_n, input, 1 bit, asynchronous, active-high.
REQ-008 fire, input, 1 bit, level-high fire request (key already inverted by top level).
REQ-009 ship_x, input, 10 bits, ship X coordinate; ship_y, input, 10 bits, ship Y coordinate.
REQ-010 ship_dir, input, 6 bits, ship heading.
REQ-011 kill, input, MAX_SHOTS bits, per-slot destroy request from the collision stage.
REQ-012 shots, output, [MAX_SHOTS-1:0][ENTITY_SIZE-1:0], packed shot words consumed by draw_controller.
REQ-013 fire_ack, output, 1 bit, one-tick pulse marking a successful spawn.
REQ-014 active_count, output, $clog2(MAX_SHOTS+1) bits, number of active slots.

Function
REQ-015 Each shot word SHALL use this layout: [33]=active, [32:30]=3'b010 (shot type), [29:26]=0, [25:16]=y, [15:6]=x, [5:0]=dir.
REQ-016 fire SHALL be registered each tick into fire_q; a spawn request SHALL be fire & ~fire_q (one request per press).
REQ-017 A spawn request SHALL succeed only when the cooldown counter is 0 and at least one slot is free.
REQ-018 A slot is free when active=0 and its kill bit is 0 in that tick; kill has priority, so a slot killed this tick is not reusable until the next tick.
REQ-019 On success, the lowest-index free slot SHALL load active=1, x=ship_x, y=ship_y, dir=ship_dir, life=LIFETIME; it SHALL NOT move in the spawn tick.
REQ-020 On success, fire_ack SHALL be 1 for exactly the following registered tick, and cooldown SHALL load COOLDOWN.
REQ-021 A failed request (cooldown nonzero or all slots full) SHALL be dropped, not queued, with fire_ack=0.
REQ-022 The cooldown counter SHALL decrement by 1 each tick while nonzero and saturate at 0.
REQ-023 For each active slot not spawned this tick: if kill[i]=1, active SHALL clear; else if life=1, active SHALL clear (expiry); else the shot SHALL move by the velocity for its dir and life SHALL decrement.
REQ-024 Velocity (dx,dy) SHALL be selected by dir[5:3]: 0:(0,-2) 1:(+2,-2) 2:(+2,0) 3:(+2,+2) 4:(0,+2) 5:(-2,+2) 6:(-2,0) 7:(-2,-2).
REQ-025 Position arithmetic SHALL be 11-bit signed; a result below 0 SHALL add SCREEN_W (or SCREEN_H), and a result at or above SCREEN_W (or SCREEN_H) SHALL subtract it.
REQ-026 Inactive slots SHALL hold all-zero words.
REQ-027 active_count SHALL equal the popcount of the registered active bits.

Reset
REQ-028 Asserting reset_n SHALL immediately clear all shot words, life counters, cooldown, fire_q, fire_ack, and active_count to 0, including mid-flight or mid-cooldown.
REQ-029 After reset is released, a fire level held high across the release SHALL spawn on the first tick, because fire_q resets to 0.

Structure
REQ-030 ENTITY_SIZE, the field bit positions, the shot type code, SCREEN_W, and SCREEN_H SHALL live in the shared package asteroids_pkg.
REQ-031 The velocity lookup SHALL be a combinational sub-module shot_velocity_lut (dir[5:3] in, signed 3-bit dx/dy out), instantiated once per slot.

Verification
REQ-032 Reset, ship (100,50), dir 0, fire pulse -> next tick shots[0]={1,010,0,50,100,0}, fire_ack=1; each later tick y decrements by 2.
REQ-033 Ship (319,10), dir 16, fire -> after the first move tick x=1, y=10 (wrap); ship (5,1), dir 56 -> after the first move tick x=3, y=239.
REQ-034 A single spawn with no kill -> active for exactly 60 ticks, then the word is 0 and active_count returns to 0.
REQ-035 Four presses spaced 10 ticks apart -> slots 0,1,2 fill and the 4th yields fire_ack=0, active_count=3; a press 5 ticks after a spawn -> dropped by cooldown.
REQ-036 With all slots full, kill=3'b010 and a fire edge in the same tick -> slot1 clears and no spawn occurs; a fire edge next tick (cooldown expired) -> spawn into slot1.
REQ-037 Assert reset_n mid-flight with 2 shots active -> all outputs 0 immediately (before the next move_clk edge).
